// File: rtl/memory_slow.sv
// Multi-cycle backing-store memory: request/ready handshake, fixed LATENCY,
// byte-masked writes and a synchronous clear of the whole array on reset.
module memory_slow #(
  parameter int BITS       = 32,
  parameter int word_depth = 256,
  parameter int addr_width = 8,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic [addr_width-1:0] addr,
  input  logic [BITS-1:0]       wdata,
  input  logic [BITS/8-1:0]     wmask,
  output logic [BITS-1:0]       rdata,
  output logic                  ready,
  output logic                  busy
);

  localparam int NBYTES = BITS / 8;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                  state;
  state_t                  state_nx;
  logic [7:0]              cnt;
  logic                    wr_l;
  logic [addr_width-1:0]   addr_l;
  logic [BITS-1:0]         wdata_l;
  logic [NBYTES-1:0]       wmask_l;
  logic [BITS-1:0]         mem [word_depth];

  logic                    accept;
  logic                    complete;
  logic                    op_wr;
  logic [addr_width-1:0]   op_addr;
  logic [BITS-1:0]         op_wdata;
  logic [NBYTES-1:0]       op_wmask;
  logic                    in_range;

  // With LATENCY=1 the access completes on the accept edge itself, so the
  // operation is taken straight from the ports while idle.
  always_comb begin
    accept   = (state == S_IDLE) && (req_read || req_write);
    op_wr    = wr_l;
    op_addr  = addr_l;
    op_wdata = wdata_l;
    op_wmask = wmask_l;
    if (state == S_IDLE) begin
      op_wr    = req_write;
      op_addr  = addr;
      op_wdata = wdata;
      op_wmask = wmask;
    end
    complete = (state == S_IDLE) ? (accept && (LATENCY == 1)) : (cnt == 8'd1);
    in_range = 32'(op_addr) < 32'(word_depth);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept && (LATENCY > 1)) state_nx = S_WAIT;
      S_WAIT: if (cnt == 8'd1)             state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      wr_l    <= 1'b0;
      addr_l  <= '0;
      wdata_l <= '0;
      wmask_l <= '0;
      rdata   <= '0;
      ready   <= 1'b0;
      // NOTE: clearing the array in reset is a behavioural-model choice; it
      // rules out mapping mem onto a vendor RAM macro.
      for (int i = 0; i < word_depth; i++) mem[i] <= '0;
    end else begin
      ready <= complete;
      if (accept) begin
        cnt     <= 8'(LATENCY - 1);
        wr_l    <= req_write;
        addr_l  <= addr;
        wdata_l <= wdata;
        wmask_l <= wmask;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 8'd1;
      end
      if (complete) begin
        if (op_wr) begin
          if (in_range) begin
            for (int k = 0; k < NBYTES; k++)
              if (op_wmask[k]) mem[op_addr][8*k +: 8] <= op_wdata[8*k +: 8];
          end
        end else begin
          rdata <= in_range ? mem[op_addr] : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_slow.sv
// Directed bench for memory_slow: a LATENCY=4 full-depth instance and a
// LATENCY=1, 200-word instance, driven from vector tables plus corner sequences.
module tb_memory_slow;

  localparam int LAT = 4;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] exp;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        req_read, req_write;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic [31:0] rdata;
  logic        ready, busy;

  logic        r1_read, r1_write;
  logic [7:0]  a1;
  logic [31:0] wd1;
  logic [3:0]  wm1;
  logic [31:0] rd1;
  logic        rdy1, bsy1;

  int          n_cmp;
  int          n_fail;
  logic [31:0] last_rd;
  logic [31:0] last_rd1;
  vec_t        tab0 [13];
  vec_t        tab1 [10];

  memory_slow #(.BITS(32), .word_depth(256), .addr_width(8), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
    .addr(addr), .wdata(wdata), .wmask(wmask),
    .rdata(rdata), .ready(ready), .busy(busy)
  );

  memory_slow #(.BITS(32), .word_depth(200), .addr_width(8), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_read(r1_read), .req_write(r1_write),
    .addr(a1), .wdata(wd1), .wmask(wm1),
    .rdata(rd1), .ready(rdy1), .busy(bsy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Starts mid-cycle with the DUT idle; ends at the negedge of the ready cycle.
  task automatic txn0(input vec_t v);
    req_write = v.wr;
    req_read  = !v.wr;
    addr      = v.addr;
    wdata     = v.wdata;
    wmask     = v.wmask;
    @(posedge clk); #1;
    req_read  = 1'b0;
    req_write = 1'b0;
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      check($sformatf("busy_a%02h_c%0d", v.addr, c), 32'(busy), 32'(c < LAT));
      check($sformatf("ready_a%02h_c%0d", v.addr, c), 32'(ready), 32'(c == LAT));
      if (c < LAT) begin
        @(posedge clk); #1;
      end
    end
    if (v.wr) begin
      check($sformatf("rdata_hold_wr_a%02h", v.addr), rdata, last_rd);
    end else begin
      check($sformatf("rdata_a%02h", v.addr), rdata, v.exp);
      last_rd = v.exp;
    end
  endtask

  task automatic txn1(input vec_t v);
    r1_write = v.wr;
    r1_read  = !v.wr;
    a1       = v.addr;
    wd1      = v.wdata;
    wm1      = v.wmask;
    @(posedge clk); #1;
    r1_read  = 1'b0;
    r1_write = 1'b0;
    @(negedge clk);
    check($sformatf("l1_ready_a%02h", v.addr), 32'(rdy1), 32'd1);
    check($sformatf("l1_busy_a%02h", v.addr), 32'(bsy1), 32'd0);
    if (v.wr) begin
      check($sformatf("l1_rdata_hold_a%02h", v.addr), rd1, last_rd1);
    end else begin
      check($sformatf("l1_rdata_a%02h", v.addr), rd1, v.exp);
      last_rd1 = v.exp;
    end
    @(posedge clk); #1;
    @(negedge clk);
    check($sformatf("l1_ready_drop_a%02h", v.addr), 32'(rdy1), 32'd0);
  endtask

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    last_rd  = '0;
    last_rd1 = '0;

    tab0[0]  = '{1'b0, 8'h10, 32'h0,        4'h0, 32'h0000_0000};
    tab0[1]  = '{1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 32'h0};
    tab0[2]  = '{1'b0, 8'h10, 32'h0,        4'h0, 32'hDEAD_BEEF};
    tab0[3]  = '{1'b1, 8'h10, 32'h11223344, 4'h5, 32'h0};
    tab0[4]  = '{1'b0, 8'h10, 32'h0,        4'h0, 32'hDE22_BE44};
    tab0[5]  = '{1'b1, 8'h10, 32'hFFFFFFFF, 4'h0, 32'h0};
    tab0[6]  = '{1'b0, 8'h10, 32'h0,        4'h0, 32'hDE22_BE44};
    tab0[7]  = '{1'b1, 8'h11, 32'hA5A5A5A5, 4'h8, 32'h0};
    tab0[8]  = '{1'b0, 8'h11, 32'h0,        4'h0, 32'hA500_0000};
    tab0[9]  = '{1'b0, 8'hFF, 32'h0,        4'h0, 32'h0000_0000};
    tab0[10] = '{1'b1, 8'hFF, 32'h01234567, 4'hF, 32'h0};
    tab0[11] = '{1'b0, 8'hFF, 32'h0,        4'h0, 32'h0123_4567};
    tab0[12] = '{1'b0, 8'h10, 32'h0,        4'h0, 32'hDE22_BE44};

    tab1[0]  = '{1'b0, 8'h05, 32'h0,        4'h0, 32'h0000_0000};
    tab1[1]  = '{1'b1, 8'h05, 32'h0BADCAFE, 4'hF, 32'h0};
    tab1[2]  = '{1'b0, 8'h05, 32'h0,        4'h0, 32'h0BAD_CAFE};
    tab1[3]  = '{1'b1, 8'hF0, 32'hFFFFFFFF, 4'hF, 32'h0};
    tab1[4]  = '{1'b0, 8'hF0, 32'h0,        4'h0, 32'h0000_0000};
    tab1[5]  = '{1'b1, 8'hC7, 32'h55AA55AA, 4'hF, 32'h0};
    tab1[6]  = '{1'b0, 8'hC7, 32'h0,        4'h0, 32'h55AA_55AA};
    tab1[7]  = '{1'b1, 8'hC8, 32'h12121212, 4'hF, 32'h0};
    tab1[8]  = '{1'b0, 8'hC8, 32'h0,        4'h0, 32'h0000_0000};
    tab1[9]  = '{1'b0, 8'h28, 32'h0,        4'h0, 32'h0000_0000};

    rst = 1'b1;
    req_read = 1'b0; req_write = 1'b0; addr = '0; wdata = '0; wmask = '0;
    r1_read = 1'b0;  r1_write = 1'b0;  a1 = '0;   wd1 = '0;   wm1 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_rdata", rdata, 32'h0);
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_l1_rdata", rd1, 32'h0);
    check("reset_l1_busy", 32'(bsy1), 32'd0);

    // Table sequence runs back-to-back: each request is presented in the ready cycle.
    for (int i = 0; i < 13; i++) txn0(tab0[i]);

    // Requests arriving while busy are dropped.
    @(posedge clk); #1;
    for (int c = 0; c <= 7; c++) begin
      req_write = (c == 0) || (c == 3);
      req_read  = (c == 2);
      addr      = (c == 0) ? 8'h30 : (c == 2) ? 8'h10 : 8'h31;
      wdata     = (c == 0) ? 32'hCAFEF00D : 32'h77777777;
      wmask     = 4'hF;
      @(negedge clk);
      check($sformatf("busy_drop_c%0d", c), 32'(busy), 32'((c >= 1) && (c <= 3)));
      check($sformatf("ready_drop_c%0d", c), 32'(ready), 32'(c == 4));
      if (c == 4) check("rdata_drop_unchanged", rdata, last_rd);
      @(posedge clk); #1;
    end
    req_read = 1'b0; req_write = 1'b0;
    txn0('{1'b0, 8'h31, 32'h0, 4'h0, 32'h0000_0000});
    txn0('{1'b0, 8'h30, 32'h0, 4'h0, 32'hCAFE_F00D});

    // Reset during an in-flight write, with a simultaneous read request.
    @(posedge clk); #1;
    req_write = 1'b1; addr = 8'h20; wdata = 32'h12345678; wmask = 4'hF;
    @(posedge clk); #1;
    req_write = 1'b0;
    @(negedge clk);
    check("abort_busy_c1", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; req_read = 1'b1; addr = 8'h10;
    @(posedge clk); #1;
    rst = 1'b0; req_read = 1'b0;
    last_rd = '0;
    for (int c = 3; c <= 6; c++) begin
      @(negedge clk);
      check($sformatf("abort_busy_c%0d", c), 32'(busy), 32'd0);
      check($sformatf("abort_ready_c%0d", c), 32'(ready), 32'd0);
      check($sformatf("abort_rdata_c%0d", c), rdata, 32'h0);
      @(posedge clk); #1;
    end
    txn0('{1'b0, 8'h20, 32'h0, 4'h0, 32'h0000_0000});
    txn0('{1'b0, 8'h10, 32'h0, 4'h0, 32'h0000_0000});
    txn0('{1'b0, 8'h30, 32'h0, 4'h0, 32'h0000_0000});

    // Single-cycle latency, 200-word instance.
    for (int i = 0; i < 10; i++) txn1(tab1[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
